// File: rtl/uart_rx_fifo.sv
// Receive-side circular buffer between the UART receiver and a host consumer.
// Registered read data with a one-cycle rd_valid pulse, occupancy status and sticky overrun.
module uart_rx_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           d_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           d_out,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overrun,
  input  logic                       clr_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             rd_accept;
  logic             wr_accept;

  // Handshake: a read is taken when rd_en is high and the buffer holds data; its word
  // appears on d_out with rd_valid high for exactly the following cycle. A write is taken
  // when wr_en is high and there is room, where a same-cycle read counts as making room.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  // Status flags depend only on the registered occupancy counter.
  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_LEVEL));

  always_ff @(posedge clk) begin
    if (rstn && wr_accept) begin
      mem[wp] <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      d_out    <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        d_out <= mem[rp];
        rp    <= rp + AW'(1);
      end
      if (wr_accept) begin
        wp <= wp + AW'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A dropped write wins over a same-cycle clear.
      if (wr_en && !wr_accept) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, AF_LEVEL=12).
// Each scenario task drives stimulus and compares outputs inline against hand-derived values.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rstn;
  logic       wr_en;
  logic [7:0] d_in;
  logic       rd_en;
  logic [7:0] d_out;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overrun;
  logic       clr_overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en),
    .d_out(d_out), .rd_valid(rd_valid), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_en = 1'b1;
    d_in  = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_word(output logic v, output logic [7:0] d);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    v = rd_valid;
    d = d_out;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wr_en = 1'b1; d_in = 8'h99; rd_en = 1'b1; clr_overrun = 1'b0;
    tick();
    tick();
    rstn = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL reset_d_out got %h exp 00", d_out); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    for (int i = 0; i < 3; i++) write_word(exp_d[i]);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL fill_count got %0d exp 3", count); end
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rd_valid !== 1'b1 || d_out !== exp_d[i])
        begin errors++; $display("FAIL drain_word%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, d_out, exp_d[i]); end
      checks++; if (count !== 5'(2 - i))
        begin errors++; $display("FAIL drain_count%0d got %0d exp %0d", i, count, 2 - i); end
    end
    rd_en = 1'b0;
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_drop got %b exp 0", rd_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
    checks++; if (d_out !== 8'h33) begin errors++; $display("FAIL drain_hold got %h exp 33", d_out); end
  endtask

  task automatic test_full_boundary();
    logic v;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      write_word(8'(i));
      checks++; if (almost_full !== ((i + 1) >= 12))
        begin errors++; $display("FAIL af_at_count%0d got %b exp %b", i + 1, almost_full, (i + 1) >= 12); end
    end
    checks++; if (full !== 1'b1 || count !== 5'd16)
      begin errors++; $display("FAIL full_state got full=%b count=%0d exp full=1 count=16", full, count); end
    write_word(8'hAA);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL full_overrun got %b exp 1", overrun); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_drop_count got %0d exp 16", count); end
    for (int i = 0; i < 16; i++) begin
      read_word(v, d);
      checks++; if (v !== 1'b1 || d !== 8'(i))
        begin errors++; $display("FAIL full_drain%0d got v=%b d=%h exp v=1 d=%h", i, v, d, 8'(i)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %b exp 1", empty); end
  endtask

  task automatic test_overrun_priority();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    for (int i = 0; i < 16; i++) write_word(8'(8'h40 + i));
    wr_en = 1'b1; d_in = 8'hBB; clr_overrun = 1'b1;
    tick();
    wr_en = 1'b0; clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear2 got %b exp 0", overrun); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovr_count got %0d exp 16", count); end
  endtask

  task automatic test_simul_boundary();
    logic v;
    logic [7:0] d;
    wr_en = 1'b1; d_in = 8'h55; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL sim_full_count got %0d exp 16", count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL sim_full_overrun got %b exp 0", overrun); end
    checks++; if (rd_valid !== 1'b1 || d_out !== 8'h40)
      begin errors++; $display("FAIL sim_full_read got v=%b d=%h exp v=1 d=40", rd_valid, d_out); end
    for (int i = 1; i < 16; i++) begin
      read_word(v, d);
      checks++; if (v !== 1'b1 || d !== 8'(8'h40 + i))
        begin errors++; $display("FAIL sim_drain%0d got v=%b d=%h exp v=1 d=%h", i, v, d, 8'(8'h40 + i)); end
    end
    read_word(v, d);
    checks++; if (v !== 1'b1 || d !== 8'h55)
      begin errors++; $display("FAIL sim_last got v=%b d=%h exp v=1 d=55", v, d); end
    wr_en = 1'b1; d_in = 8'h66; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL sim_empty_valid got %b exp 0", rd_valid); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL sim_empty_count got %0d exp 1", count); end
    checks++; if (d_out !== 8'h55) begin errors++; $display("FAIL sim_empty_nobypass got %h exp 55", d_out); end
    read_word(v, d);
    checks++; if (v !== 1'b1 || d !== 8'h66)
      begin errors++; $display("FAIL sim_empty_word got v=%b d=%h exp v=1 d=66", v, d); end
  endtask

  task automatic test_wrap_reset();
    int n = 0;
    int cyc = 0;
    bit do_wr, do_rd;
    logic [7:0] exp_d;
    exp_q.delete();
    while ((n < 40 || exp_q.size() > 0) && cyc < 200) begin
      do_wr = (n < 40) && (exp_q.size() < 10);
      do_rd = (exp_q.size() > 0) && (cyc % 3 != 0);
      wr_en = do_wr; d_in = 8'(n * 7 + 3); rd_en = do_rd;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      if (do_rd) begin
        exp_d = exp_q.pop_front();
        checks++; if (rd_valid !== 1'b1 || d_out !== exp_d)
          begin errors++; $display("FAIL wrap_read cyc%0d got v=%b d=%h exp v=1 d=%h", cyc, rd_valid, d_out, exp_d); end
      end else begin
        checks++; if (rd_valid !== 1'b0)
          begin errors++; $display("FAIL wrap_idle cyc%0d got v=%b exp 0", cyc, rd_valid); end
      end
      if (do_wr) begin
        exp_q.push_back(8'(n * 7 + 3));
        n++;
      end
      checks++; if (count !== 5'(exp_q.size()))
        begin errors++; $display("FAIL wrap_count cyc%0d got %0d exp %0d", cyc, count, exp_q.size()); end
      cyc++;
    end
    checks++; if (cyc >= 200) begin errors++; $display("FAIL wrap_budget got %0d cycles exp <200", cyc); end
    for (int i = 0; i < 5; i++) write_word(8'(8'hC0 + i));
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL rst_pre_count got %0d exp 5", count); end
    rstn = 1'b0; wr_en = 1'b1; d_in = 8'hEE; rd_en = 1'b1;
    tick();
    rstn = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (empty !== 1'b1 || count !== 5'd0)
      begin errors++; $display("FAIL rst_mid got empty=%b count=%0d exp empty=1 count=0", empty, count); end
    rd_en = 1'b1;
    tick();
    tick();
    rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_read_valid got %b exp 0", rd_valid); end
    checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL rst_read_d_out got %h exp 00", d_out); end
  endtask

  initial begin
    rstn = 1'b0; wr_en = 1'b0; d_in = '0; rd_en = 1'b0; clr_overrun = 1'b0;
    test_reset();
    test_fill_drain();
    test_full_boundary();
    test_overrun_priority();
    test_simul_boundary();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each validated byte presented with the receiver's one-cycle FIFO write strobe and holds it in a circular buffer. A host-side consumer drains it through a read handshake with registered read data. Status outputs are full, empty, almost-full, occupancy and a sticky overrun flag.

## Interface
Parameters:
- WIDTH, 8, data word width; matches the receiver data width.
- DEPTH, 16, number of entries; power of two, ≥ 4.
- AF_LEVEL, 12, occupancy at or above which `almost_full` asserts; 1 ≤ AF_LEVEL ≤ DEPTH.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rstn  input  1  synchronous, active-low reset.
- wr_en  input  1  write strobe, driven by the receiver's FIFO write-enable.
- d_in  input  WIDTH  write data, driven by the receiver's data output; sampled when wr_en=1.
- rd_en  input  1  read request from consumer.
- d_out  output  WIDTH  registered read data.
- rd_valid  output  1  one-cycle pulse; d_out holds a newly popped word.
- empty  output  1  occupancy == 0.
- full  output  1  occupancy == DEPTH.
- almost_full  output  1  occupancy ≥ AF_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overrun  output  1  sticky; a write was dropped because the FIFO was full.
- clr_overrun  input  1  clears overrun.

## Operation
- Storage is DEPTH×WIDTH. Write pointer `wp` and read pointer `rp` are each $clog2(DEPTH) bits and wrap modulo DEPTH with natural overflow. Occupancy is held in a separate counter.
- **Write accept:** wr_en && (!full || rd_accept). On accept, mem[wp] ← d_in and wp ← wp+1.
- **Read accept:** `rd_accept` = rd_en && !empty. On accept, d_out ← mem[rp], rp ← rp+1, and rd_valid=1 on the next cycle.
- **count update:** +1 on write-only accept; −1 on read-only accept; unchanged on both or neither.
- **Full + simultaneous read and write:** both are accepted. The read frees the slot, count stays DEPTH, and overrun is not set.
- **Empty + simultaneous read and write:** the read is ignored and the write is accepted. count becomes 1. The new word is not bypassed, so d_out is unchanged and rd_valid=0.
- **Write while full without a read:** the word is dropped and pointers and contents are unchanged. overrun ← 1.
- **Read while empty:** ignored. d_out holds its previous value, rd_valid=0, and there is no error flag.
- **overrun:** set has priority over clr_overrun in the same cycle. Otherwise clr_overrun=1 clears it on the next edge.
- empty, full, almost_full and count are registered, or derived combinationally from the registered count only. They never depend combinationally on wr_en or rd_en.

## Timing
- **Reset:** rstn=0 sampled at a clock edge sets wp=rp=0, count=0, empty=1, full=0, almost_full=0, overrun=0, d_out=0, rd_valid=0. Memory contents are not reset.
- Reset asserted mid-operation discards all buffered data at that edge. Any wr_en or rd_en in the same cycle is ignored.
- **Write-to-status latency:** 1 cycle. A word written at edge N makes count/empty reflect it after edge N.
- **Write-to-read:** a word written at edge N can be read with rd_en in the cycle after edge N at the earliest. Its data appears on d_out after the next edge.
- **Read latency:** rd_en sampled at edge N; d_out and rd_valid are valid after edge N and rd_valid drops after edge N+1 unless another read is accepted. Back-to-back reads sustain one word per cycle.
- **Write throughput:** one word per cycle. The receiver issues at most one strobe per received frame.

## Test plan
- **Reset defaults:** hold rstn=0 for 2 cycles with wr_en=1 → after release, empty=1, full=0, count=0, d_out=0, rd_valid=0, overrun=0.
- **In-order fill and drain:** write 0x11,0x22,0x33, then rd_en for 3 cycles → d_out sequence 0x11,0x22,0x33 with rd_valid high 3 cycles. count goes 3→0 and empty=1 at the end.
- **Full boundary, DEPTH=16:** write 0x00..0x0F → full=1, count=16, almost_full asserted from count=12. Write 0xAA → overrun=1, and the following 16 reads return 0x00..0x0F (0xAA absent).
- **Overrun priority:** with overrun=1, assert clr_overrun → overrun=0 next cycle. Repeat with clr_overrun and a dropped write in the same cycle → overrun stays 1.
- **Simultaneous read and write at boundaries:** at full, wr_en=1 (0x55) with rd_en=1 → count stays 16, overrun=0, and 0x55 is read last. At empty, both asserted → rd_valid=0 and count=1.
- **Pointer wrap and reset mid-stream:** stream 40 words with interleaved reads, keeping ≤10 buffered → all data in order across wraps. Assert rstn=0 with 5 words buffered → empty=1, and subsequent reads return no rd_valid.
